// File: rtl/sr04_report_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sr04_report_sequencer
// Description : Periodic HC-SR04 measurement scheduler, BCD conversion, 7-byte
//               UART report streamer and proximity alarm with hysteresis.
// Revision    : 1.0 - initial release
// ============================================================================
module sr04_report_sequencer #(
    parameter int PERIOD_CYC  = 600000,
    parameter int TIMEOUT_CYC = 360000,
    parameter int ALARM_NEAR  = 5,
    parameter int ALARM_FAR   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_en,
    output logic        measure,
    input  logic        sensor_ready,
    input  logic [15:0] distance_cm,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] last_distance,
    output logic        timeout_flag,
    output logic        alarm,
    output logic        busy
);

    localparam int c_PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int c_TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_PW-1:0] c_PERIOD_LAST  = c_PW'(PERIOD_CYC - 1);
    localparam logic [c_TW-1:0] c_TIMEOUT_LAST = c_TW'(TIMEOUT_CYC - 1);
    localparam logic [15:0]     c_NEAR         = 16'(ALARM_NEAR);
    localparam logic [15:0]     c_FAR          = 16'(ALARM_FAR);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TRIG     = 3'd1,
        S_WAIT_RDY = 3'd2,
        S_CONVERT  = 3'd3,
        S_SEND     = 3'd4
    } state_t;

    state_t          r_state;
    logic [c_PW-1:0] r_period_cnt;
    logic [c_TW-1:0] r_timeout_cnt;
    logic            r_rdy_d;
    logic [15:0]     r_value;
    logic [1:0]      r_place;
    logic [19:0]     r_digits;
    logic [2:0]      r_byte_idx;
    logic            w_tick;
    logic [2:0]      w_dsel;

    assign w_tick = start_en && (r_period_cnt == c_PERIOD_LAST);
    assign w_dsel = 3'd4 - {1'b0, r_place};

    function automatic logic [15:0] place_value(input logic [1:0] idx);
        case (idx)
            2'd0:    place_value = 16'd10000;
            2'd1:    place_value = 16'd1000;
            2'd2:    place_value = 16'd100;
            default: place_value = 16'd10;
        endcase
    endfunction

    // ASCII is the digit with high nibble 3; a digit of 4'hF yields '?'.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [19:0] d);
        case (idx)
            3'd0:    frame_byte = {4'h3, d[19:16]};
            3'd1:    frame_byte = {4'h3, d[15:12]};
            3'd2:    frame_byte = {4'h3, d[11:8]};
            3'd3:    frame_byte = {4'h3, d[7:4]};
            3'd4:    frame_byte = {4'h3, d[3:0]};
            3'd5:    frame_byte = 8'h0D;
            default: frame_byte = 8'h0A;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst || !start_en || w_tick) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_timeout_cnt <= '0;
            r_rdy_d       <= 1'b0;
            r_value       <= '0;
            r_place       <= '0;
            r_digits      <= '0;
            r_byte_idx    <= '0;
            measure       <= 1'b0;
            tx_data       <= 8'h00;
            tx_valid      <= 1'b0;
            last_distance <= '0;
            timeout_flag  <= 1'b0;
            alarm         <= 1'b0;
            busy          <= 1'b0;
        end else begin
            r_rdy_d <= sensor_ready;
            measure <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state <= S_TRIG;
                        measure <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_TRIG: begin
                    r_timeout_cnt <= '0;
                    r_state       <= S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    if (sensor_ready && !r_rdy_d) begin
                        r_value       <= distance_cm;
                        last_distance <= distance_cm;
                        timeout_flag  <= 1'b0;
                        if (distance_cm <= c_NEAR) begin
                            alarm <= 1'b1;
                        end else if (distance_cm >= c_FAR) begin
                            alarm <= 1'b0;
                        end
                        r_place  <= '0;
                        r_digits <= '0;
                        r_state  <= S_CONVERT;
                    end else if (r_timeout_cnt == c_TIMEOUT_LAST) begin
                        timeout_flag <= 1'b1;
                        r_digits     <= {5{4'hF}};
                        r_byte_idx   <= '0;
                        tx_data      <= 8'h3F;
                        tx_valid     <= 1'b1;
                        r_state      <= S_SEND;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 1'b1;
                    end
                end
                S_CONVERT: begin
                    if (r_value >= place_value(r_place)) begin
                        r_value                  <= r_value - place_value(r_place);
                        r_digits[w_dsel*4 +: 4]  <= r_digits[w_dsel*4 +: 4] + 4'd1;
                    end else if (r_place == 2'd3) begin
                        r_digits[3:0] <= r_value[3:0];
                        r_byte_idx    <= '0;
                        tx_data       <= {4'h3, r_digits[19:16]};
                        tx_valid      <= 1'b1;
                        r_state       <= S_SEND;
                    end else begin
                        r_place <= r_place + 1'b1;
                    end
                end
                S_SEND: begin
                    if (tx_valid && tx_ready) begin
                        if (r_byte_idx == 3'd6) begin
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            tx_data    <= frame_byte(r_byte_idx + 3'd1, r_digits);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
